// File: rtl/inv_sqrt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : inv_sqrt_pkg
//  Purpose  : Shared types, constants and fixed<->single conversion helpers
//             for the fast inverse square root block.
//  Contents : state_t          - FSM state encoding
//             DEFAULT_MAGIC    - bit-hack constant
//             fix_to_single()  - unsigned Q(int.fract) -> IEEE754 single
//             single_to_fix()  - IEEE754 single -> unsigned Q(int.fract)
//  Revision : 1.0 - initial release
// ============================================================================
package inv_sqrt_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TO_FLOAT = 3'd1,
    HACK     = 3'd2,
    TO_FIX   = 3'd3,
    NR       = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [31:0] DEFAULT_MAGIC = 32'h5f3759df;

  // Fixed-point value (zero-extended to 64 bits) to a positive single.
  // The exponent is the leading-one position relative to the binary point;
  // mantissa bits below the leading one are left-aligned and truncated.
  function automatic logic [31:0] fix_to_single(input logic [63:0] x,
                                                input int int_w,
                                                input int fract_w);
    int          p;
    int          w;
    logic [22:0] m;
    logic [7:0]  e;
    w = int_w + fract_w;
    p = 0;
    for (int i = 0; i < 64; i++) begin
      if (i < w && x[i]) p = i;
    end
    if (p >= 23) m = 23'(x >> (p - 23));
    else         m = 23'(x << (23 - p));
    e = 8'(p - fract_w + 127);
    return {1'b0, e, m};
  endfunction

  // Positive single back to fixed point, truncating. Values whose leading
  // one lands at or above bit w saturate to all-ones in the low w bits.
  function automatic logic [63:0] single_to_fix(input logic [31:0] s,
                                                input int int_w,
                                                input int fract_w);
    int          sh;
    int          w;
    logic [7:0]  e;
    logic [63:0] sig;
    logic [63:0] r;
    w   = int_w + fract_w;
    e   = s[30:23];
    sig = {40'd0, 1'b1, s[22:0]};
    sh  = int'({24'd0, e}) - 127 + fract_w - 23;
    if (sh >= 0) begin
      if (sh + 23 >= w) r = (64'd1 << w) - 64'd1;
      else              r = sig << sh;
    end else if (sh <= -24) begin
      r = 64'd0;
    end else begin
      r = sig >> (-sh);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inv_sqrt_nr_step.sv
`default_nettype none
// ============================================================================
//  Module   : inv_sqrt_nr_step
//  Purpose  : One combinational Newton-Raphson refinement of 1/sqrt(x):
//             y_next = y * (1.5 - x_half * y * y)
//  Ports    : y       in  W  current estimate, Q(INT.FRACT)
//             x_half  in  W  x/2, Q(INT.FRACT)
//             y_next  out W  refined estimate, saturated to all-ones
//  Revision : 1.0 - initial release
// ============================================================================
module inv_sqrt_nr_step #(
  parameter int INT_WIDTH   = 16,
  parameter int FRACT_WIDTH = 16
) (
  input  logic [INT_WIDTH+FRACT_WIDTH-1:0] y,
  input  logic [INT_WIDTH+FRACT_WIDTH-1:0] x_half,
  output logic [INT_WIDTH+FRACT_WIDTH-1:0] y_next
);

  localparam int W  = INT_WIDTH + FRACT_WIDTH;
  localparam int W2 = 2 * W;

  localparam logic [W2-1:0] C_THREE_HALVES = W2'(3) << (FRACT_WIDTH - 1);
  localparam logic [W2-1:0] C_MAX_OUT      = {{W{1'b0}}, {W{1'b1}}};

  logic [W2-1:0] w_yy;
  logic [W2-1:0] w_t;
  logic [W2-1:0] w_term;
  logic [W2-1:0] w_prod;

  // All products are held at 2W bits; anything above wraps.
  assign w_yy   = (W2'(y) * W2'(y)) >> FRACT_WIDTH;
  assign w_t    = (W2'(x_half) * w_yy) >> FRACT_WIDTH;
  assign w_term = (w_t > C_THREE_HALVES) ? '0 : (C_THREE_HALVES - w_t);
  assign w_prod = (W2'(y) * w_term) >> FRACT_WIDTH;
  assign y_next = (w_prod > C_MAX_OUT) ? '1 : w_prod[W-1:0];

endmodule
`default_nettype wire

// File: rtl/fast_inv_sqrt_iter.sv
`default_nettype none
// ============================================================================
//  Module   : fast_inv_sqrt_iter
//  Purpose  : Multi-cycle 1/sqrt(x) for unsigned Q(INT.FRACT) inputs using
//             the magic-constant bit hack followed by NR_ITERS Newton-Raphson
//             refinements. Fixed latency of 4+NR_ITERS cycles to valid_out.
//  Ports    : clk, rst_n                 clock, async active-low reset
//             data_in/tag_in/valid_in    request; ready_in high only in IDLE
//             data_out/tag_out/err_out   result; valid_out held until
//             valid_out/ready_out        ready_out accepts it
//             busy                       high whenever not IDLE
//  Revision : 1.0 - initial release
// ============================================================================
import inv_sqrt_pkg::*;

module fast_inv_sqrt_iter #(
  parameter int          INT_WIDTH   = 16,
  parameter int          FRACT_WIDTH = 16,
  parameter int          NR_ITERS    = 2,
  parameter int          TAG_WIDTH   = 4,
  parameter logic [31:0] MAGIC       = DEFAULT_MAGIC
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [INT_WIDTH+FRACT_WIDTH-1:0] data_in,
  input  logic [TAG_WIDTH-1:0]             tag_in,
  input  logic                             valid_in,
  output logic                             ready_in,
  output logic [INT_WIDTH+FRACT_WIDTH-1:0] data_out,
  output logic [TAG_WIDTH-1:0]             tag_out,
  output logic                             err_out,
  output logic                             valid_out,
  input  logic                             ready_out,
  output logic                             busy
);

  localparam int         W           = INT_WIDTH + FRACT_WIDTH;
  localparam logic [2:0] C_LAST_ITER = 3'((NR_ITERS > 0) ? NR_ITERS - 1 : 0);

  state_t               r_state;
  state_t               w_state_next;
  logic [W-1:0]         r_x;
  logic [TAG_WIDTH-1:0] r_tag;
  logic                 r_err;
  logic [31:0]          r_single;
  logic [W-1:0]         r_y;
  logic [2:0]           r_iter;
  logic [W-1:0]         w_x_half;
  logic [W-1:0]         w_y_next;

  assign ready_in = (r_state == IDLE);
  assign busy     = (r_state != IDLE);
  assign w_x_half = r_x >> 1;

  inv_sqrt_nr_step #(
    .INT_WIDTH   (INT_WIDTH),
    .FRACT_WIDTH (FRACT_WIDTH)
  ) u_nr_step (
    .y      (r_y),
    .x_half (w_x_half),
    .y_next (w_y_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (valid_in) w_state_next = TO_FLOAT;
      TO_FLOAT: w_state_next = HACK;
      HACK:     w_state_next = TO_FIX;
      TO_FIX:   w_state_next = (NR_ITERS == 0) ? DONE : NR;
      NR:       if (r_iter == C_LAST_ITER) w_state_next = DONE;
      DONE:     if (valid_out && ready_out) w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  // Datapath. r_single holds the converted input and then, after HACK, the
  // bit-hack estimate. The first DONE cycle loads the output registers, which
  // gives the fixed 4+NR_ITERS latency; a zero input bypasses the float
  // result with the saturated value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x       <= '0;
      r_tag     <= '0;
      r_err     <= 1'b0;
      r_single  <= '0;
      r_y       <= '0;
      r_iter    <= '0;
      data_out  <= '0;
      tag_out   <= '0;
      err_out   <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid_in) begin
            r_x    <= data_in;
            r_tag  <= tag_in;
            r_err  <= (data_in == '0);
            r_iter <= '0;
          end
        end
        TO_FLOAT: r_single <= fix_to_single(64'(r_x), INT_WIDTH, FRACT_WIDTH);
        HACK:     r_single <= MAGIC - (r_single >> 1);
        TO_FIX:   r_y <= W'(single_to_fix(r_single, INT_WIDTH, FRACT_WIDTH));
        NR: begin
          r_y    <= w_y_next;
          r_iter <= r_iter + 3'd1;
        end
        DONE: begin
          if (!valid_out) begin
            valid_out <= 1'b1;
            data_out  <= r_err ? '1 : r_y;
            tag_out   <= r_tag;
            err_out   <= r_err;
          end else if (ready_out) begin
            valid_out <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
